// File: rtl/dpll_pkg.sv
// rtl/dpll_pkg.sv - entry layout and backtrack FSM encodings for the DPLL trail stack
package dpll_pkg;

   localparam int LIT_W_DEF = 8;
   // Entry word: {lit, dec, val}
   localparam int VAL_BIT = 0;
   localparam int DEC_BIT = 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_UNWIND = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/dpll_trail_mem.sv
// rtl/dpll_trail_mem.sv - trail entry array, synchronous write, combinational read
module dpll_trail_mem
   import dpll_pkg::*;
#(
   parameter int LIT_W = LIT_W_DEF,
   parameter int DEPTH = 16,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               i_we,
   input  logic [CNT_W-1:0]   i_waddr,
   input  logic [LIT_W+1:0]   i_wdata,
   input  logic [CNT_W-1:0]   i_raddr,
   output logic [LIT_W+1:0]   o_rdata
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [LIT_W+1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr[AW-1:0]] <= i_wdata;
      end
   end

   // An empty stack reads at count-1 which wraps past DEPTH; report a zero entry there.
   assign o_rdata = (i_raddr < DEPTH_C) ? r_mem[i_raddr[AW-1:0]] : '0;

endmodule

// File: rtl/dpll_trail_stack.sv
// rtl/dpll_trail_stack.sv - DPLL assignment trail with decision-level tracking and unwind
module dpll_trail_stack
   import dpll_pkg::*;
#(
   parameter int LIT_W = LIT_W_DEF,
   parameter int DEPTH = 16,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic [LIT_W-1:0]   push_lit,
   input  logic               push_val,
   input  logic               push_dec,
   input  logic               pop,
   input  logic               bt_req,
   input  logic [CNT_W-1:0]   bt_level,
   output logic [LIT_W-1:0]   top_lit,
   output logic               top_val,
   output logic               top_dec,
   output logic [CNT_W-1:0]   count,
   output logic [CNT_W-1:0]   dec_level,
   output logic               empty,
   output logic               full,
   output logic               busy,
   output logic               unw_valid,
   output logic [LIT_W-1:0]   unw_lit,
   output logic               unw_val,
   output logic               bt_done,
   output logic               err
);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_count, r_dec_level, r_bt_level;
   logic [CNT_W-1:0]   w_count_nxt, w_dec_nxt, w_waddr, w_raddr;
   logic [CNT_W-1:0]   w_push_dec_x, w_top_dec_x;
   logic [LIT_W+1:0]   w_wdata, w_rdata;
   logic               w_we, w_rem, w_err_set, w_bt_lat;
   logic               w_empty, w_full;
   logic               r_unw_valid, r_unw_val, r_bt_done, r_err;
   logic [LIT_W-1:0]   r_unw_lit;

   dpll_trail_mem #(.LIT_W(LIT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_mem (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   assign w_raddr      = r_count - ONE;
   assign w_empty      = (r_count == '0);
   assign w_full       = (r_count == DEPTH_C);
   assign w_push_dec_x = {{(CNT_W-1){1'b0}}, push_dec};
   assign w_top_dec_x  = {{(CNT_W-1){1'b0}}, w_rdata[DEC_BIT]};

   always_comb begin
      w_state_nxt = r_state;
      w_we        = 1'b0;
      w_waddr     = r_count;
      w_wdata     = {push_lit, push_dec, push_val};
      w_count_nxt = r_count;
      w_dec_nxt   = r_dec_level;
      w_rem       = 1'b0;
      w_err_set   = 1'b0;
      w_bt_lat    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bt_req) begin
               w_bt_lat    = 1'b1;
               w_state_nxt = (bt_level >= r_dec_level) ? ST_DONE : ST_UNWIND;
            end else if (push && pop && !w_empty) begin
               w_we      = 1'b1;
               w_waddr   = r_count - ONE;
               w_rem     = 1'b1;
               w_dec_nxt = r_dec_level + w_push_dec_x - w_top_dec_x;
            end else if (push) begin
               if (w_full) begin
                  w_err_set = 1'b1;
               end else begin
                  w_we        = 1'b1;
                  w_count_nxt = r_count + ONE;
                  w_dec_nxt   = r_dec_level + w_push_dec_x;
               end
            end else if (pop) begin
               if (w_empty) begin
                  w_err_set = 1'b1;
               end else begin
                  w_rem       = 1'b1;
                  w_count_nxt = r_count - ONE;
                  w_dec_nxt   = r_dec_level - w_top_dec_x;
               end
            end
         end
         ST_UNWIND: begin
            // bt_level < dec_level on entry, so a decision entry always lies below the top.
            w_rem       = 1'b1;
            w_count_nxt = r_count - ONE;
            w_dec_nxt   = r_dec_level - w_top_dec_x;
            w_err_set   = push | pop;
            if (w_rdata[DEC_BIT] && ((r_dec_level - ONE) == r_bt_level)) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_err_set   = push | pop;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_count     <= '0;
         r_dec_level <= '0;
         r_bt_level  <= '0;
         r_unw_valid <= 1'b0;
         r_unw_lit   <= '0;
         r_unw_val   <= 1'b0;
         r_bt_done   <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_count     <= w_count_nxt;
         r_dec_level <= w_dec_nxt;
         r_unw_valid <= w_rem;
         r_bt_done   <= (r_state == ST_DONE);
         if (w_bt_lat) begin
            r_bt_level <= bt_level;
         end
         if (w_rem) begin
            r_unw_lit <= w_rdata[LIT_W+1:2];
            r_unw_val <= w_rdata[VAL_BIT];
         end
         if (w_err_set) begin
            r_err <= 1'b1;
         end
      end
   end

   assign top_lit   = w_rdata[LIT_W+1:2];
   assign top_val   = w_rdata[VAL_BIT];
   assign top_dec   = w_rdata[DEC_BIT];
   assign count     = r_count;
   assign dec_level = r_dec_level;
   assign empty     = w_empty;
   assign full      = w_full;
   assign busy      = (r_state != ST_IDLE);
   assign unw_valid = r_unw_valid;
   assign unw_lit   = r_unw_lit;
   assign unw_val   = r_unw_val;
   assign bt_done   = r_bt_done;
   assign err       = r_err;

endmodule

// File: tb/tb_dpll_trail_stack.sv
// tb/tb_dpll_trail_stack.sv - self-checking bench for dpll_trail_stack against a queue model
module tb_dpll_trail_stack;

   localparam int LIT_W = 8;
   localparam int DEPTH = 16;
   localparam int CNT_W = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             push = 1'b0, push_val = 1'b0, push_dec = 1'b0, pop = 1'b0, bt_req = 1'b0;
   logic [LIT_W-1:0] push_lit = '0;
   logic [CNT_W-1:0] bt_level = '0;
   logic [LIT_W-1:0] top_lit, unw_lit;
   logic             top_val, top_dec, empty, full, busy, unw_valid, unw_val, bt_done, err;
   logic [CNT_W-1:0] count, dec_level;

   dpll_trail_stack dut (
      .clk(clk), .rst(rst), .push(push), .push_lit(push_lit), .push_val(push_val),
      .push_dec(push_dec), .pop(pop), .bt_req(bt_req), .bt_level(bt_level),
      .top_lit(top_lit), .top_val(top_val), .top_dec(top_dec), .count(count),
      .dec_level(dec_level), .empty(empty), .full(full), .busy(busy),
      .unw_valid(unw_valid), .unw_lit(unw_lit), .unw_val(unw_val),
      .bt_done(bt_done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [LIT_W-1:0] lit;
      logic             val;
      logic             dec;
   } ent_t;

   ent_t q[$];
   bit   m_err;
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic int m_dec();
      int d = 0;
      foreach (q[i]) if (q[i].dec) d++;
      return d;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag);
      ent_t t;
      t = (q.size() > 0) ? q[$] : '0;
      chk({tag, ".count"}, 32'(count), 32'(q.size()));
      chk({tag, ".dec_level"}, 32'(dec_level), 32'(m_dec()));
      chk({tag, ".top_lit"}, 32'(top_lit), 32'(t.lit));
      chk({tag, ".top_val"}, 32'(top_val), 32'(t.val));
      chk({tag, ".top_dec"}, 32'(top_dec), 32'(t.dec));
      chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
      chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
      chk({tag, ".err"}, 32'(err), 32'(m_err));
      chk({tag, ".busy"}, 32'(busy), 32'(0));
   endtask

   task automatic do_reset();
      rst = 1'b0;
      cycle();
      cycle();
      rst = 1'b1;
      q.delete();
      m_err = 1'b0;
      chk("rst.unw_valid", 32'(unw_valid), 32'(0));
      chk("rst.bt_done", 32'(bt_done), 32'(0));
      check_state("rst");
   endtask

   task automatic op(input bit p, input logic [LIT_W-1:0] lit, input bit v, input bit d,
                     input bit po, input string tag);
      bit   exp_unw = 1'b0;
      ent_t ul = '0;
      ent_t ne;
      ne = '{lit: lit, val: v, dec: d};
      if (p && po && q.size() > 0) begin
         exp_unw = 1'b1;
         ul = q[$];
         q[q.size() - 1] = ne;
      end else if (p) begin
         if (q.size() == DEPTH) m_err = 1'b1;
         else q.push_back(ne);
      end else if (po) begin
         if (q.size() == 0) m_err = 1'b1;
         else begin
            exp_unw = 1'b1;
            ul = q.pop_back();
         end
      end
      push = p; push_lit = lit; push_val = v; push_dec = d; pop = po;
      cycle();
      push = 1'b0; pop = 1'b0;
      chk({tag, ".unw_valid"}, 32'(unw_valid), 32'(exp_unw));
      if (exp_unw) begin
         chk({tag, ".unw_lit"}, 32'(unw_lit), 32'(ul.lit));
         chk({tag, ".unw_val"}, 32'(unw_val), 32'(ul.val));
      end
      check_state(tag);
   endtask

   task automatic bt(input int level, input bit poke_done, input string tag);
      ent_t rem[$];
      while (m_dec() > level) rem.push_back(q.pop_back());
      bt_req = 1'b1; bt_level = CNT_W'(level);
      cycle();
      bt_req = 1'b0;
      chk({tag, ".busy0"}, 32'(busy), 32'(1));
      chk({tag, ".unw0"}, 32'(unw_valid), 32'(0));
      chk({tag, ".done0"}, 32'(bt_done), 32'(0));
      foreach (rem[i]) begin
         cycle();
         chk({tag, ".unw_valid"}, 32'(unw_valid), 32'(1));
         chk({tag, ".unw_lit"}, 32'(unw_lit), 32'(rem[i].lit));
         chk({tag, ".unw_val"}, 32'(unw_val), 32'(rem[i].val));
         chk({tag, ".busy"}, 32'(busy), 32'(1));
         chk({tag, ".done_early"}, 32'(bt_done), 32'(0));
      end
      if (poke_done) begin
         push = 1'b1; push_lit = 8'hEE; push_dec = 1'b1;
         m_err = 1'b1;
      end
      cycle();
      push = 1'b0;
      chk({tag, ".bt_done"}, 32'(bt_done), 32'(1));
      chk({tag, ".unw_end"}, 32'(unw_valid), 32'(0));
      check_state(tag);
   endtask

   task automatic build_trail();
      op(1, 8'd3, 1, 0, 0, "tr3");
      op(1, 8'd7, 0, 1, 0, "tr7");
      op(1, 8'd8, 1, 0, 0, "tr8");
      op(1, 8'd9, 1, 1, 0, "tr9");
      op(1, 8'd2, 0, 0, 0, "tr2");
      op(1, 8'd4, 1, 0, 0, "tr4");
   endtask

   initial begin
      int r, lvl;
      do_reset();

      op(1, 8'd5, 1, 0, 0, "p5");
      op(1, 8'd15, 0, 0, 0, "p15");
      op(1, 8'd1, 1, 0, 0, "p1");
      for (int i = 0; i < 3; i++) op(0, '0, 0, 0, 1, "pop3");
      op(0, '0, 0, 0, 1, "pop_empty");

      do_reset();
      for (int i = 0; i < DEPTH; i++) op(1, LIT_W'(i + 32), i[0], i[1], 0, "fill");
      op(1, 8'hAA, 1, 1, 0, "push_full");
      op(1, 8'h55, 0, 1, 1, "pushpop_full");

      do_reset();
      op(1, 8'd42, 1, 1, 1, "pushpop_empty");
      do_reset();
      build_trail();
      bt(1, 0, "bt1");
      do_reset();
      build_trail();
      bt(0, 0, "bt0");
      do_reset();
      build_trail();
      bt(3, 1, "bt3");

      do_reset();
      op(1, 8'd7, 0, 1, 0, "s7");
      op(1, 8'd6, 1, 0, 1, "swap6");
      op(1, 8'd9, 1, 1, 0, "s9");
      op(1, 8'd2, 0, 0, 0, "s2");
      bt_req = 1'b1; bt_level = '0;
      cycle();
      bt_req = 1'b0;
      cycle();
      chk("midrst.unw_valid", 32'(unw_valid), 32'(1));
      chk("midrst.unw_lit", 32'(unw_lit), 32'(2));
      rst = 1'b0;
      cycle();
      rst = 1'b1;
      q.delete();
      m_err = 1'b0;
      chk("midrst.bt_done", 32'(bt_done), 32'(0));
      check_state("midrst");

      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 11);
         if (r <= 4)
            op(1, LIT_W'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0), 0, "rnd_push");
         else if (r <= 7)
            op(0, '0, 0, 0, 1, "rnd_pop");
         else if (r <= 9)
            op(1, LIT_W'($urandom), 1'($urandom), 1'($urandom), 1, "rnd_pp");
         else begin
            lvl = $urandom_range(0, m_dec() + 1);
            bt(lvl, ($urandom_range(0, 3) == 0), "rnd_bt");
         end
         if (i % 100 == 99) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
